// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator: FSM state
// encoding and the default maximum pattern length.
package seqgen_pkg;

    localparam int MAX_LEN_DEFAULT = 8;

    // 2'b11 is unreachable in normal operation and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10,
        BAD   = 2'b11
    } state_t;

endpackage

// File: rtl/seqgen_shifter.sv
// Datapath of the sequence generator: MSB-aligned pattern load,
// shift-left register and bits-remaining down-counter.
// Look-ahead outputs let the top register w_out/bit_count in step
// with the shift register itself.
module seqgen_shifter
    import seqgen_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CW      = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               load,
    input  logic               shift,
    input  logic               clear,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CW-1:0]      len,
    output logic               next_msb,
    output logic [CW-1:0]      next_cnt,
    output logic [CW-1:0]      cnt
);

    logic [MAX_LEN-1:0] sreg;
    logic [MAX_LEN-1:0] sreg_next;
    logic [CW-1:0]      cnt_next;
    logic [CW-1:0]      pad;

    // Next register contents: clear wins, then load (bit[len-1] moved to the MSB), then shift
    always_comb begin
        pad       = CW'(MAX_LEN) - len;
        sreg_next = sreg;
        cnt_next  = cnt;
        if (clear) begin
            sreg_next = '0;
            cnt_next  = '0;
        end else if (load) begin
            sreg_next = pattern << pad;
            cnt_next  = len;
        end else if (shift) begin
            sreg_next = sreg << 1;
            cnt_next  = cnt - CW'(1);
        end
    end

    // Shift register and counter state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            sreg <= sreg_next;
            cnt  <= cnt_next;
        end
    end

    assign next_msb = sreg_next[MAX_LEN-1];
    assign next_cnt = cnt_next;

endmodule

// File: rtl/sequence_generator.sv
// Serial sequence generator: on start, sends the low `length` bits of
// `pattern` MSB first on w_out, then pulses done for one cycle.
// Optional feature: define SEQGEN_REPEAT_EN to let repeat_req reload
// the pattern seamlessly at the end of each run.
// The continuous-loop input is named repeat_req because `repeat` is a
// reserved word.
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CW      = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CW-1:0]      length,
    input  logic               repeat_req,
    output logic               w_out,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      bit_count,
    output logic [1:0]         state
);

    state_t        state_q;
    state_t        state_next;
    logic          load;
    logic          shift;
    logic          clear;
    logic          reload_ok;
    logic          next_msb;
    logic [CW-1:0] next_cnt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len_clamped;

    assign len_clamped = (length > CW'(MAX_LEN)) ? CW'(MAX_LEN) : length;

`ifdef SEQGEN_REPEAT_EN
    assign reload_ok = repeat_req && (length != '0);
`else
    logic unused_repeat;
    assign unused_repeat = repeat_req;
    assign reload_ok     = 1'b0;
`endif

    seqgen_shifter #(
        .MAX_LEN(MAX_LEN),
        .CW     (CW)
    ) u_shifter (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
        .pattern (pattern),
        .len     (len_clamped),
        .next_msb(next_msb),
        .next_cnt(next_cnt),
        .cnt     (cnt)
    );

    // Next-state and datapath control; start is only looked at in IDLE
    always_comb begin
        state_next = IDLE;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    if (reload_ok) begin
                        state_next = SHIFT;
                        load       = 1'b1;
                    end else begin
                        state_next = DONE;
                        clear      = 1'b1;
                    end
                end else begin
                    state_next = SHIFT;
                    shift      = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                state_next = IDLE;
                clear      = 1'b1;
            end
        endcase
    end

    // State and registered outputs, all derived from the upcoming state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            w_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
        end else begin
            state_q   <= state_next;
            w_out     <= (state_next == SHIFT) && next_msb;
            busy      <= (state_next == SHIFT);
            done      <= (state_next == DONE);
            bit_count <= (state_next == SHIFT) ? next_cnt : '0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator (MAX_LEN=8, CW=4).
// A queue-based model of the bits still to be sent predicts every
// output each cycle; directed scenarios add hand-computed literals.
// Build with SEQGEN_REPEAT_EN defined to exercise the repeat feature.
module tb_sequence_generator;

    localparam int MAX_LEN = 8;
    localparam int CW      = 4;
`ifdef SEQGEN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic               clock;
    logic               resetn;
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [CW-1:0]      length;
    logic               repeat_req;
    logic               w_out;
    logic               busy;
    logic               done;
    logic [CW-1:0]      bit_count;
    logic [1:0]         state;

    int n_checks = 0;
    int n_fail   = 0;

    sequence_generator #(
        .MAX_LEN(MAX_LEN),
        .CW     (CW)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .pattern   (pattern),
        .length    (length),
        .repeat_req(repeat_req),
        .w_out     (w_out),
        .busy      (busy),
        .done      (done),
        .bit_count (bit_count),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of bits still to appear on w_out
    bit q[$];
    bit m_done;
    bit was_done;

    task automatic fill(input logic [MAX_LEN-1:0] p, input int len);
        int n;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = n - 1; i >= 0; i--) q.push_back(p[i]);
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            if (q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (REP && repeat_req && (length != 0)) fill(pattern, int'(length));
                    else m_done = 1'b1;
                end
            end else if (!was_done && start && (length != 0)) begin
                fill(pattern, int'(length));
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check("model w_out", 32'(w_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("model busy", 32'(busy), 32'(q.size() > 0));
        check("model done", 32'(done), 32'(m_done));
        check("model bit_count", 32'(bit_count), 32'(q.size()));
        check("model state", 32'(state), (q.size() > 0) ? 32'd1 : (m_done ? 32'd2 : 32'd0));
    end

    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [MAX_LEN-1:0] p, input logic [CW-1:0] l);
        pattern = p;
        length  = l;
        start   = 1'b1;
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp8;
        logic [3:0] exp4;
        int ones;

        clock      = 1'b0;
        resetn     = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        length     = '0;
        repeat_req = 1'b0;
        #1 resetn  = 1'b0;
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset w_out", 32'(w_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bit_count", 32'(bit_count), 32'd0);
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;

        // 0x0D, length 4 -> 1,1,0,1 then done, first start right after reset
        send(8'h0D, 4'd4);
        exp4 = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("basic w_out", 32'(w_out), 32'(exp4[3-i]));
            check("basic busy", 32'(busy), 32'd1);
            check("basic bit_count", 32'(bit_count), 32'(4 - i));
        end
        @(negedge clock);
        check("basic done", 32'(done), 32'd1);
        check("basic done w_out", 32'(w_out), 32'd0);
        @(negedge clock);
        check("basic idle state", 32'(state), 32'd0);
        check("basic idle done", 32'(done), 32'd0);

        // length 0 is ignored
        sync();
        send(8'hFF, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("len0 busy", 32'(busy), 32'd0);
            check("len0 done", 32'(done), 32'd0);
            check("len0 state", 32'(state), 32'd0);
        end

        // length 12 clamps to 8, 0xA5 sent from bit 7
        sync();
        send(8'hA5, 4'd12);
        exp8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("clamp w_out", 32'(w_out), 32'(exp8[7-i]));
            check("clamp bit_count", 32'(bit_count), 32'(8 - i));
        end
        @(negedge clock);
        check("clamp done", 32'(done), 32'd1);

        // start/pattern/length changes during a run have no effect
        sync();
        send(8'hB4, 4'd6);
        pattern = 8'hFF;
        length  = 4'd3;
        start   = 1'b1;
        repeat (7) @(posedge clock);
        #2 start = 1'b0;
        @(negedge clock);
        check("ignore start state", 32'(state), 32'd0);
        check("ignore start busy", 32'(busy), 32'd0);

        // single-bit run
        sync();
        send(8'h01, 4'd1);
        @(negedge clock);
        check("len1 w_out", 32'(w_out), 32'd1);
        check("len1 bit_count", 32'(bit_count), 32'd1);
        @(negedge clock);
        check("len1 done", 32'(done), 32'd1);

        // repeat request: loops only when the feature is built in
        sync();
        repeat_req = 1'b1;
        send(8'h0D, 4'd4);
`ifdef SEQGEN_REPEAT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("repeat w_out", 32'(w_out), 32'(exp4[3-(i%4)]));
            check("repeat no done", 32'(done), 32'd0);
            if (i == 5) repeat_req = 1'b0;
        end
        @(negedge clock);
        check("repeat end done", 32'(done), 32'd1);
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("norepeat w_out", 32'(w_out), 32'(exp4[3-i]));
        end
        @(negedge clock);
        check("norepeat done", 32'(done), 32'd1);
        repeat_req = 1'b0;
`endif

        // closed loop: a 1111 detector fires on the 4th bit
        sync();
        send(8'h0F, 4'd4);
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ones = w_out ? ones + 1 : 0;
            check("detector", 32'(ones >= 4), 32'(i == 3));
        end

        // reset during the third bit of an 8-bit run
        sync();
        send(8'hFF, 4'd8);
        repeat (2) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("midrun reset w_out", 32'(w_out), 32'd0);
        check("midrun reset state", 32'(state), 32'd0);
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset bit_count", 32'(bit_count), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("post reset no done", 32'(done), 32'd0);
            check("post reset state", 32'(state), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..16.
REQ-002 Parameter CW, default 4: width of length and bit_count; SHALL satisfy 2**CW > MAX_LEN.
REQ-003 clock input 1: single clock; all state changes on its rising edge.
REQ-004 resetn input 1: asynchronous, active-low reset.
REQ-005 start input 1: request to transmit, sampled on the rising edge of clock.
REQ-006 pattern input MAX_LEN: bits to send; bit[length-1] is sent first, bit[0] last.
REQ-007 length input CW: number of bits to send.
REQ-008 repeat input 1: continuous-loop request; used only under SEQGEN_REPEAT_EN.
REQ-009 w_out output 1: serial bit stream, registered, compatible with the detector's w input.
REQ-010 busy output 1: high while bits are being transmitted.
REQ-011 done output 1: one-cycle pulse after the last bit of a non-repeating run.
REQ-012 bit_count output CW: bits remaining, including the bit currently on w_out.
REQ-013 state output 2: current FSM state, for LED display.

Function
REQ-014 The FSM SHALL have states IDLE=2'b00, SHIFT=2'b01 and DONE=2'b10; code 2'b11 SHALL go to IDLE on the next edge.
REQ-015 IDLE: if start=1 and length≠0, capture pattern and min(length, MAX_LEN) and go to SHIFT; otherwise stay in IDLE.
REQ-016 Latency: if start is sampled at edge k, the first bit SHALL appear on w_out after edge k, and busy SHALL be 1 from edge k on.
REQ-017 SHIFT: each edge SHALL present the next bit on w_out and decrement bit_count; the output order is MSB of the captured length first.
REQ-018 When bit_count=1 in SHIFT with no repeat reload, the next edge SHALL enter DONE with w_out=0, busy=0, done=1 and bit_count=0.
REQ-019 DONE SHALL always go to IDLE on the next edge, so done is high for exactly one cycle.
REQ-020 start SHALL be ignored in SHIFT and DONE; pattern and length changes after capture SHALL have no effect.
REQ-021 In IDLE, w_out=0, busy=0, done=0 and bit_count=0.
REQ-022 A length greater than MAX_LEN SHALL be clamped to MAX_LEN; length=0 SHALL be ignored with no busy and no done.

Reset
REQ-023 resetn=0 SHALL immediately force state=IDLE, w_out=0, busy=0, done=0, bit_count=0 and clear the shift register, including in the middle of a transmission.
REQ-024 After resetn deasserts, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-025 Macro SEQGEN_REPEAT_EN, when defined: if repeat=1 when the last bit is on w_out, the next edge SHALL reload the current pattern and length inputs and continue in SHIFT with no gap bit and no done pulse.
REQ-026 When SEQGEN_REPEAT_EN is not defined, the repeat port SHALL remain present but be ignored, and every run SHALL end through DONE.

Structure
REQ-027 Package seqgen_pkg SHALL hold the state encoding constants (IDLE, SHIFT, DONE) and the MAX_LEN default.
REQ-028 Sub-module seqgen_shifter SHALL hold the MSB-aligned load, the shift-left register and the down-counter; the top level holds the FSM and output registers.

Verification
REQ-029 With pattern=8'h0D, length=4 and a start pulse, w_out SHALL be 1,1,0,1 on the four cycles after start, then done=1 for one cycle, then IDLE.
REQ-030 With length=0 and start=1, busy, done and w_out SHALL stay 0 and state SHALL stay 2'b00.
REQ-031 With length=12 and MAX_LEN=8, exactly 8 bits SHALL be sent (pattern[7] first), and bit_count SHALL start at 8.
REQ-032 Pulsing resetn low during the third bit of an 8-bit run SHALL immediately give w_out=0 and state=IDLE, and no done pulse SHALL follow.
REQ-033 Under SEQGEN_REPEAT_EN, with repeat=1, pattern=4'b1101 and length=4, w_out SHALL be 1101 1101 … with no gap; dropping repeat SHALL end the run after the current pattern with done=1.
REQ-034 Closed loop: w_out feeding the sequence detector with pattern 1111 SHALL raise the detector output on the 4th bit.
